// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS program-counter sequencer.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_COMMIT,
    S_ADVANCE,
    S_WAIT_STEP,
    S_DONE
  } seq_state_t;

  localparam logic [5:0]  HALT_OPCODE  = 6'b111111;
  localparam int unsigned DEF_PC_STEP  = 1;
  localparam int unsigned DEF_SETTLE   = 2;
  localparam int unsigned DEF_PROG_LEN = 16;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned TMR_W        = 4;

endpackage

// File: rtl/mips_sequencer_settle_timer.sv
// Settle-window down-counter: loads a start value, counts to zero and holds there.
module settle_timer
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] value,
  output logic             zero
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/mips_sequencer.sv
// Steps the datapath PC through a program: settle, commit write strobes, advance.
// Supports free-run, single-step, halt-on-opcode and abort.
module mips_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned PC_STEP  = DEF_PC_STEP,
  parameter int unsigned PROG_LEN = DEF_PROG_LEN,
  parameter int unsigned SETTLE   = DEF_SETTLE,
  parameter logic [5:0]  HALT_OP  = HALT_OPCODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step,
  input  logic        abort,
  input  logic [31:0] instruction,
  input  logic        regw_in,
  input  logic        memw_in,
  output logic [31:0] pc,
  output logic        reg_wr_en,
  output logic        mem_wr_en,
  output logic        busy,
  output logic        done,
  output logic        halted_on_op,
  output logic [15:0] instr_count
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_count;
  logic             r_halted;
  logic             r_done;
  logic             r_step_mode;

  logic             w_load;
  logic             w_start;
  logic             w_commit;
  logic             w_halt;
  logic             w_adv;
  logic             w_zero;
  logic [5:0]       w_opcode;
  logic             w_unused_ok;

  assign w_opcode    = instruction[31:26];
  assign w_unused_ok = ^instruction[25:0];

  settle_timer u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .value (TMR_W'(SETTLE - 1)),
    .zero  (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_count     <= '0;
      r_halted    <= 1'b0;
      r_done      <= 1'b0;
      r_step_mode <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE) && (w_next == S_DONE);
      if (w_start) begin
        r_pc        <= '0;
        r_count     <= '0;
        r_halted    <= 1'b0;
        r_step_mode <= step_mode;
      end
      if (w_adv) begin
        r_pc <= r_pc + 32'(PC_STEP);
      end
      if (w_commit && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Next-state decode; abort outranks start, which outranks step.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_start  = 1'b0;
    w_commit = 1'b0;
    w_halt   = 1'b0;
    w_adv    = 1'b0;
    if (abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_start = 1'b1;
            w_load  = 1'b1;
            w_next  = S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_zero) begin
            w_next = S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (w_opcode == HALT_OP) begin
            w_halt = 1'b1;
            w_next = S_DONE;
          end else begin
            w_commit = 1'b1;
            w_next   = S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          w_adv = 1'b1;
          if (r_count == CNT_W'(PROG_LEN)) begin
            w_next = S_DONE;
          end else if (r_step_mode) begin
            w_next = S_WAIT_STEP;
          end else begin
            w_load = 1'b1;
            w_next = S_EXEC;
          end
        end
        S_WAIT_STEP: begin
          if (step) begin
            w_load = 1'b1;
            w_next = S_EXEC;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign pc           = r_pc;
  assign reg_wr_en    = w_commit & regw_in & ~abort;
  assign mem_wr_en    = w_commit & memw_in & ~abort;
  assign busy         = (r_state == S_EXEC) || (r_state == S_COMMIT) || (r_state == S_ADVANCE);
  assign done         = r_done;
  assign halted_on_op = r_halted;
  assign instr_count  = r_count;

endmodule

// File: tb/tb_mips_sequencer.sv
// Scoreboard bench for mips_sequencer: a program-level model predicts each
// write strobe (cycle, pc, kind) and the end-of-run state.
module tb_mips_sequencer;
  import mips_pkg::*;

  localparam int unsigned PL   = 3;
  localparam int unsigned ST   = 2;
  localparam int unsigned STEP = 1;
  localparam int          IC   = int'(ST) + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] instruction;
  logic        regw_in, memw_in;
  logic [31:0] pc;
  logic        reg_wr_en, mem_wr_en, busy, done, halted_on_op;
  logic [15:0] instr_count;

  logic [5:0]  p_op [16];
  logic [25:0] p_lo [16];
  logic        p_rw [16];
  logic        p_mw [16];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        rw;
    logic        mw;
  } exp_t;
  exp_t sb[$];

  mips_sequencer #(.PC_STEP(STEP), .PROG_LEN(PL), .SETTLE(ST), .HALT_OP(HALT_OPCODE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .abort(abort), .instruction(instruction), .regw_in(regw_in), .memw_in(memw_in),
    .pc(pc), .reg_wr_en(reg_wr_en), .mem_wr_en(mem_wr_en), .busy(busy), .done(done),
    .halted_on_op(halted_on_op), .instr_count(instr_count)
  );

  // Instruction memory and control unit stand-in, indexed by the live pc.
  assign instruction = {p_op[pc[3:0]], p_lo[pc[3:0]]};
  assign regw_in     = p_rw[pc[3:0]];
  assign memw_in     = p_mw[pc[3:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every visible strobe must match the oldest predicted commit.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((reg_wr_en === 1'b1) || (mem_wr_en === 1'b1))) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'({reg_wr_en, mem_wr_en}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        chk("strobe_pc", pc, e.pc);
        chk("strobe_kind", 32'({reg_wr_en, mem_wr_en}), 32'({e.rw, e.mw}));
        chk("strobe_busy", 32'(busy), 32'd1);
      end
    end
  end

  task automatic fill_prog(input logic [5:0] op, input logic rw, input logic mw);
    for (int i = 0; i < 16; i++) begin
      p_op[i] = op;
      p_lo[i] = 26'($urandom);
      p_rw[i] = rw;
      p_mw[i] = mw;
    end
  endtask

  task automatic rand_prog(input int halt_pct);
    for (int i = 0; i < 16; i++) begin
      p_op[i] = (int'($urandom_range(0, 99)) < halt_pct) ? HALT_OPCODE : 6'($urandom_range(0, 62));
      p_lo[i] = 26'($urandom);
      p_rw[i] = 1'($urandom);
      p_mw[i] = 1'($urandom);
    end
  endtask

  // Program-level model: walk the program, predict commits and how the run ends.
  task automatic model_run(input int c0, input int max_ev, output int n, output bit halted, output int idx);
    n = 0;
    halted = 1'b0;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      idx = i;
      if (p_op[i] == HALT_OPCODE) begin
        halted = 1'b1;
        break;
      end
      if ((n < max_ev) && (p_rw[i] || p_mw[i]))
        sb.push_back('{c0 + i * IC + int'(ST), 32'(i * int'(STEP)), p_rw[i], p_mw[i]});
      n++;
      if (n == int'(PL)) break;
    end
  endtask

  task automatic do_start(input bit sm, output int c0);
    @(negedge clk);
    start = 1'b1;
    step_mode = sm;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    step_mode = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int exp_edge);
    bit seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        chk("done_edge", 32'(cyc - c0), 32'(exp_edge));
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Free run of whatever program is loaded, including the start-clears check.
  task automatic run_prog();
    int c0, n, idx;
    bit h;
    do_start(1'b0, c0);
    model_run(c0, 99, n, h, idx);
    @(negedge clk);
    chk("start_clr_pc", pc, 32'd0);
    chk("start_clr_cnt", 32'(instr_count), 32'd0);
    chk("start_clr_halt", 32'(halted_on_op), 32'd0);
    chk("start_clr_done", 32'(done), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    wait_done(c0, h ? idx * IC + int'(ST) + 2 : n * IC + 1);
    chk("end_pc", pc, h ? 32'(idx * int'(STEP)) : 32'(n * int'(STEP)));
    chk("end_count", 32'(instr_count), 32'(n));
    chk("end_halted", 32'(halted_on_op), 32'(h));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic step_test();
    int c0, s0;
    fill_prog(6'd0, 1'b1, 1'b0);
    p_mw[1] = 1'b1;
    do_start(1'b1, c0);
    sb.push_back('{c0 + int'(ST), 32'd0, 1'b1, 1'b0});
    repeat (5) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      chk("wait_pc", pc, 32'(STEP));
      chk("wait_busy", 32'(busy), 32'd0);
      start = (k == 10);
      @(negedge clk);
    end
    start = 1'b0;
    for (int j = 1; j < int'(PL); j++) begin
      step = 1'b1;
      @(posedge clk);
      #1;
      s0 = cyc;
      step = 1'b0;
      sb.push_back('{s0 + int'(ST), 32'(j * int'(STEP)), 1'b1, p_mw[j]});
      if (j < int'(PL) - 1) begin
        repeat (5) @(negedge clk);
        chk("step_wait_pc", pc, 32'((j + 1) * int'(STEP)));
        chk("step_wait_busy", 32'(busy), 32'd0);
      end
    end
    wait_done(s0, int'(ST) + 3);
    chk("step_end_pc", pc, 32'(PL * STEP));
    chk("step_end_count", 32'(instr_count), 32'(PL));
    chk("step_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic abort_test();
    int c0, n, idx;
    bit h;
    fill_prog(6'd0, 1'b0, 1'b1);
    p_rw[1] = 1'b1;
    do_start(1'b0, c0);
    model_run(c0, 1, n, h, idx);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    #1;
    chk("abort_mem_gated", 32'(mem_wr_en), 32'd0);
    chk("abort_reg_gated", 32'(reg_wr_en), 32'd0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pc", pc, 32'(STEP));
    chk("abort_count", 32'(instr_count), 32'd1);
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic reset_test();
    int c0, n, idx;
    bit h;
    fill_prog(6'd0, 1'b1, 1'b0);
    do_start(1'b0, c0);
    model_run(c0, 1, n, h, idx);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_pc", pc, 32'(STEP));
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'd0);
    chk("async_rst_count", 32'(instr_count), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("rst_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    fill_prog(6'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_halted", 32'(halted_on_op), 32'd0);
    chk("rst_strobes", 32'({reg_wr_en, mem_wr_en}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All R-type with RegW.
    fill_prog(6'd0, 1'b1, 1'b0);
    run_prog();
    // Halt at pc=1; the halt word carries RegW/MemW that must not strobe.
    fill_prog(6'd0, 1'b1, 1'b0);
    p_op[1] = HALT_OPCODE;
    p_mw[1] = 1'b1;
    run_prog();
    // Stores only.
    fill_prog(6'h2b, 1'b0, 1'b1);
    run_prog();

    step_test();
    abort_test();
    reset_test();

    for (int r = 0; r < 12; r++) begin
      rand_prog(20);
      run_prog();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_sequencer.md
# mips_sequencer

Clocked sequencer that owns the program counter of the single-cycle MIPS datapath and steps it through a program held in instruction memory. It drives `pc`, waits a fixed settle window for the combinational fetch, decode, ALU and memory path, and then issues one-cycle register-file and main-memory write strobes. The block sits above the top-level datapath, between the testbench or host and the datapath. It supports free-run, single-step, halt-on-opcode and abort.

## Interface
Parameters:
- `PC_STEP`, 1: increment applied to `pc` per instruction (1 means word index, 4 means byte address).
- `PROG_LEN`, 16: number of instructions executed before automatic completion; range 1..65535.
- `SETTLE`, 2: cycles `pc` is held stable before commit; range 1..15.
- `HALT_OP`, 6'b111111: opcode (`instruction[31:26]`) that terminates execution without committing.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  start pulse; honoured only in IDLE or DONE.
- `step_mode`  in  1  sampled with `start`; 1 selects single-step.
- `step`  in  1  advance one instruction while in WAIT_STEP.
- `abort`  in  1  return to IDLE; highest priority.
- `instruction`  in  32  instruction word fetched at the current `pc`.
- `regw_in`  in  1  RegW from the control unit.
- `memw_in`  in  1  MemW from the control unit.
- `pc`  out  32  program counter driven to the datapath.
- `reg_wr_en`  out  1  register-file write strobe.
- `mem_wr_en`  out  1  main-memory write strobe.
- `busy`  out  1  asserted in EXEC, COMMIT or ADVANCE.
- `done`  out  1  asserted in DONE.
- `halted_on_op`  out  1  sticky flag: the last run ended on `HALT_OP`.
- `instr_count`  out  16  number of instructions committed in the current run.

## Operation
States are IDLE, EXEC, COMMIT, ADVANCE, WAIT_STEP and DONE.

Transitions:
- IDLE or DONE, on `start`:
  - clear `pc`, `instr_count` and `halted_on_op`;
  - latch `step_mode`;
  - move to EXEC and load the settle counter with SETTLE-1.
- EXEC: decrement the settle counter each cycle; move to COMMIT when it reaches 0.
- COMMIT, when `instruction[31:26]==HALT_OP`:
  - no strobes;
  - set `halted_on_op`;
  - move to DONE.
- COMMIT, otherwise:
  - `reg_wr_en=regw_in`, `mem_wr_en=memw_in` for this one cycle;
  - `instr_count` increments;
  - move to ADVANCE.
- ADVANCE: `pc <= pc + PC_STEP`, wrapping modulo 2^32. Then:
  - if `instr_count==PROG_LEN`, move to DONE;
  - else if single-step is latched, move to WAIT_STEP;
  - else move to EXEC and reload the counter.
- WAIT_STEP: on `step`, move to EXEC and reload the counter; `start` is ignored in this state.
- DONE: hold `pc` and `instr_count`; `start` begins a new run from `pc=0`.

Abort:
- `abort` in any state other than IDLE moves to IDLE at the next edge.
- `pc` and `instr_count` keep their values.
- A strobe in the same cycle as `abort` is suppressed; strobes are gated combinationally by `~abort`.

Other rules:
- `busy` is decoded from the state. `done`, `halted_on_op` and `instr_count` come from registers.
- `instr_count` saturates at 16'hFFFF.
- Simultaneous events are resolved in priority order: `abort` > `start` > `step`.

## Timing
- Reset (asynchronous, while `rst_n=0`):
  - state=IDLE;
  - `pc=0`, `instr_count=0`;
  - `reg_wr_en=mem_wr_en=busy=done=halted_on_op=0`.
- Per-instruction cost is SETTLE+2 cycles; with the default SETTLE=2 that is 4 cycles.
- Free run:
  - `start` sampled at edge 0;
  - first commit strobe is high during cycle SETTLE+1;
  - `done` rises PROG_LEN×(SETTLE+2)+1 edges after edge 0.
- `pc` changes only at ADVANCE (and on clear at start); it is stable for every EXEC and COMMIT cycle.
- Strobes are high for exactly one cycle per committed instruction and only in COMMIT.
- Reset deasserted mid-run: the run is lost and the block resumes in IDLE.

## Structure
- Shared package `mips_pkg` holds:
  - the `seq_state_t` enum;
  - the HALT opcode constant;
  - the default PC_STEP, SETTLE and PROG_LEN values.
- One sub-module, `settle_timer`: a 4-bit down-counter with `load`/`value` inputs and a `zero` output, used by EXEC.
- The datapath is not instantiated here; the top level connects `pc`, `instruction`, the control-unit RegW/MemW and the write strobes.

## Test plan
- PROG_LEN=3, SETTLE=2, free run, all instructions R-type with RegW=1 -> `reg_wr_en` pulses at cycles 3, 7, 11; `pc` goes 1, 2, 3; `done` rises at edge 13; `instr_count`=3.
- HALT_OP at `pc`=1 -> one commit; `halted_on_op`=1; `done`=1; `pc`=1; `instr_count`=1; no strobe in the halt COMMIT.
- Single-step with `step_mode`=1 -> after the first ADVANCE, WAIT_STEP is held for 20 cycles with `pc`=1 and `busy`=0; a `step` pulse produces the next commit exactly SETTLE+1 cycles later.
- `abort` asserted in a COMMIT where MemW=1 -> `mem_wr_en` stays 0; state returns to IDLE; `pc` and `instr_count` are unchanged.
- Store instruction (MemW=1, RegW=0) -> only `mem_wr_en` pulses, for 1 cycle.
- `start` from DONE after a run, and `rst_n` dropped mid-EXEC -> both return `pc` and `instr_count` to 0; reset takes effect asynchronously, before the next clock edge.
